// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: light color codes and controller state encodings,
// used by both the light controller and the sensor/queue block.
package tl_pkg;

   typedef enum logic [1:0] {
      GREEN  = 2'b00,
      YELLOW = 2'b01,
      RED    = 2'b11
   } light_t;

   // Code 2'b10 is never driven by a healthy controller.
   localparam logic [1:0] LIGHT_ILLEGAL = 2'b10;

   typedef enum logic [1:0] {
      S_A_GREEN  = 2'b00,
      S_A_YELLOW = 2'b01,
      S_B_GREEN  = 2'b10,
      S_B_YELLOW = 2'b11
   } ctrl_state_t;

   // Departure timer width; covers DEPART_CYCLES up to 15.
   localparam int TIMER_W = 4;

   function automatic logic is_green(input logic [1:0] code);
      return code == GREEN;
   endfunction

   // Only the three forward steps that skip a color are illegal.
   function automatic logic bad_transition(input logic [1:0] prev, input logic [1:0] cur);
      return ((prev == GREEN)  && (cur == RED))    ||
             ((prev == RED)    && (cur == YELLOW)) ||
             ((prev == YELLOW) && (cur == GREEN));
   endfunction

endpackage

// File: rtl/tl_queue.sv
// One street's vehicle queue: saturating arrival counter with a green-time
// departure timer and a sticky overflow flag.
module tl_queue
   import tl_pkg::*;
#(
   parameter int QW            = 4,
   parameter int DEPART_CYCLES = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          arr,
   input  logic          green,
   output logic [QW-1:0] q,
   output logic          t,
   output logic          ovf
);

   localparam logic [QW-1:0]      Q_MAX    = {QW{1'b1}};
   localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(DEPART_CYCLES - 1);

   logic [QW-1:0]      q_p1;
   logic [TIMER_W-1:0] timer_p1;
   logic               ovf_p1;

   logic               running;
   logic               depart;
   logic               drop;
   logic [QW-1:0]      q_nxt;
   logic [TIMER_W-1:0] timer_nxt;

   // Arrival and departure cancel; a lone arrival saturates at Q_MAX, a lone
   // departure cannot underflow because departures need a nonempty queue.
   function automatic logic [QW-1:0] q_update(input logic [QW-1:0] cur,
                                               input logic          inc,
                                               input logic          dec);
      logic [QW-1:0] res;
      res = cur;
      if (inc && !dec && (cur != Q_MAX))
         res = cur + 1'b1;
      else if (dec && !inc && (cur != '0))
         res = cur - 1'b1;
      return res;
   endfunction

   always_comb begin
      running   = green && (q_p1 != '0);
      depart    = running && (timer_p1 == TIMER_END);
      drop      = arr && !depart && (q_p1 == Q_MAX);
      q_nxt     = q_update(q_p1, arr, depart);
      timer_nxt = '0;
      if (running && !depart)
         timer_nxt = timer_p1 + 1'b1;
   end

   // stage p1: registered queue state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_p1     <= '0;
         timer_p1 <= '0;
         ovf_p1   <= 1'b0;
      end else begin
         q_p1     <= q_nxt;
         timer_p1 <= timer_nxt;
         if (drop)
            ovf_p1 <= 1'b1;
      end
   end

   assign q   = q_p1;
   assign t   = (q_p1 != '0);
   assign ovf = ovf_p1;

endmodule

// File: rtl/tl_sensor.sv
// Traffic sensor: per-street vehicle queues driving the Ta/Tb presence signals,
// plus a light monitor flagging illegal codes, transitions and conflicts.
module tl_sensor
   import tl_pkg::*;
#(
   parameter int QW            = 4,
   parameter int DEPART_CYCLES = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          arr_a,
   input  logic          arr_b,
   input  logic [1:0]    La,
   input  logic [1:0]    Lb,
   output logic          Ta,
   output logic          Tb,
   output logic [QW-1:0] qa,
   output logic [QW-1:0] qb,
   output logic [1:0]    ovf,
   output logic [2:0]    err
);

   logic       ovf_a;
   logic       ovf_b;
   logic [1:0] la_p1;
   logic [1:0] lb_p1;
   logic [2:0] err_p1;
   logic [2:0] err_now;

   tl_queue #(
      .QW            (QW),
      .DEPART_CYCLES (DEPART_CYCLES)
   ) u_queue_a (
      .clk     (clk),
      .reset_n (reset_n),
      .arr     (arr_a),
      .green   (is_green(La)),
      .q       (qa),
      .t       (Ta),
      .ovf     (ovf_a)
   );

   tl_queue #(
      .QW            (QW),
      .DEPART_CYCLES (DEPART_CYCLES)
   ) u_queue_b (
      .clk     (clk),
      .reset_n (reset_n),
      .arr     (arr_b),
      .green   (is_green(Lb)),
      .q       (qb),
      .t       (Tb),
      .ovf     (ovf_b)
   );

   always_comb begin
      err_now    = '0;
      err_now[0] = (La == LIGHT_ILLEGAL) || (Lb == LIGHT_ILLEGAL);
      err_now[1] = bad_transition(la_p1, La) || bad_transition(lb_p1, Lb);
      err_now[2] = (La != RED) && (Lb != RED);
   end

   // stage p1: previous lights and sticky error flags; reset mirrors the controller's reset state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         la_p1  <= GREEN;
         lb_p1  <= RED;
         err_p1 <= '0;
      end else begin
         la_p1  <= La;
         lb_p1  <= Lb;
         err_p1 <= err_p1 | err_now;
      end
   end

   assign ovf = {ovf_b, ovf_a};
   assign err = err_p1;

endmodule

// File: tb/tb_tl_sensor.sv
// Directed bench for tl_sensor (QW=4, DEPART_CYCLES=3) with hand-computed expectations.
module tb_tl_sensor;

   localparam logic [1:0] C_GREEN  = 2'b00;
   localparam logic [1:0] C_YELLOW = 2'b01;
   localparam logic [1:0] C_RED    = 2'b11;
   localparam logic [1:0] C_BAD    = 2'b10;

   logic       clk;
   logic       reset_n;
   logic       arr_a;
   logic       arr_b;
   logic [1:0] La;
   logic [1:0] Lb;
   logic       Ta;
   logic       Tb;
   logic [3:0] qa;
   logic [3:0] qb;
   logic [1:0] ovf;
   logic [2:0] err;

   int checks = 0;
   int errors = 0;

   tl_sensor #(
      .QW            (4),
      .DEPART_CYCLES (3)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .arr_a   (arr_a),
      .arr_b   (arr_b),
      .La      (La),
      .Lb      (Lb),
      .Ta      (Ta),
      .Tb      (Tb),
      .qa      (qa),
      .qb      (qb),
      .ovf     (ovf),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset asynchronously between clock edges, leaving inputs at the controller reset state.
   task automatic do_reset();
      arr_a = 1'b0;
      arr_b = 1'b0;
      La    = C_GREEN;
      Lb    = C_RED;
      @(negedge clk);
      reset_n = 1'b0;
      #2;
      check("rst_qa", 32'(qa), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      reset_n = 1'b1;
      arr_a   = 1'b0;
      arr_b   = 1'b0;
      La      = C_GREEN;
      Lb      = C_RED;
      #2;
      reset_n = 1'b0;
      #10;
      check("reset_qa", 32'(qa), 32'd0);
      check("reset_qb", 32'(qb), 32'd0);
      check("reset_Ta", 32'(Ta), 32'd0);
      check("reset_Tb", 32'(Tb), 32'd0);
      check("reset_ovf", 32'(ovf), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;

      // Three arrivals on A while A is red, then A turns green and drains.
      La    = C_RED;
      Lb    = C_GREEN;
      arr_a = 1'b1;
      tick(1);
      check("arr_first_qa", 32'(qa), 32'd1);
      tick(2);
      arr_a = 1'b0;
      check("fill_qa", 32'(qa), 32'd3);
      check("fill_Ta", 32'(Ta), 32'd1);
      La = C_YELLOW;
      Lb = C_RED;
      tick(1);
      check("yellow_qa", 32'(qa), 32'd3);
      La = C_GREEN;
      tick(2);
      check("green2_qa", 32'(qa), 32'd3);
      tick(1);
      check("green3_qa", 32'(qa), 32'd2);
      tick(3);
      check("green6_qa", 32'(qa), 32'd1);
      tick(2);
      check("green8_qa", 32'(qa), 32'd1);
      check("green8_Ta", 32'(Ta), 32'd1);
      tick(1);
      check("green9_qa", 32'(qa), 32'd0);
      check("green9_Ta", 32'(Ta), 32'd0);
      tick(3);
      check("empty_qa", 32'(qa), 32'd0);
      check("drain_qb", 32'(qb), 32'd0);
      check("drain_Tb", 32'(Tb), 32'd0);

      // Saturation and overflow on A.
      do_reset();
      La    = C_RED;
      Lb    = C_RED;
      arr_a = 1'b1;
      tick(15);
      check("full_qa", 32'(qa), 32'd15);
      check("full_ovf", 32'(ovf), 32'd0);
      tick(1);
      arr_a = 1'b0;
      check("ovf_qa", 32'(qa), 32'd15);
      check("ovf_flag", 32'(ovf), 32'd1);
      check("ovf_qb", 32'(qb), 32'd0);
      tick(2);
      check("ovf_sticky", 32'(ovf), 32'd1);

      // Arrival coinciding with a departure leaves the count unchanged.
      do_reset();
      La    = C_RED;
      Lb    = C_RED;
      arr_a = 1'b1;
      tick(3);
      arr_a = 1'b0;
      La    = C_GREEN;
      tick(3);
      check("dep_qa", 32'(qa), 32'd2);
      tick(2);
      check("predep_qa", 32'(qa), 32'd2);
      arr_a = 1'b1;
      tick(1);
      arr_a = 1'b0;
      check("arrdep_qa", 32'(qa), 32'd2);
      check("arrdep_ovf", 32'(ovf), 32'd0);
      tick(1);
      check("arrdep_next_qa", 32'(qa), 32'd2);

      // Street B queue and its departure.
      do_reset();
      La    = C_RED;
      Lb    = C_GREEN;
      arr_b = 1'b1;
      #1;
      check("b_before_edge", 32'(qb), 32'd0);
      tick(1);
      arr_b = 1'b0;
      check("b_qb", 32'(qb), 32'd1);
      check("b_Tb", 32'(Tb), 32'd1);
      tick(2);
      check("b_hold_qb", 32'(qb), 32'd1);
      tick(1);
      check("b_dep_qb", 32'(qb), 32'd0);
      check("b_dep_Tb", 32'(Tb), 32'd0);

      // Illegal GREEN->RED on A, sticky through a legal sequence.
      do_reset();
      La = C_GREEN;
      Lb = C_RED;
      tick(1);
      check("legal_err", 32'(err), 32'd0);
      La = C_RED;
      tick(1);
      check("trans_err", 32'(err), 32'b010);
      La = C_GREEN;
      tick(1);
      La = C_YELLOW;
      tick(1);
      La = C_RED;
      tick(1);
      check("trans_sticky", 32'(err), 32'b010);

      // Illegal code, then cleared by reset.
      do_reset();
      La = C_BAD;
      Lb = C_RED;
      tick(1);
      check("code_err", 32'(err), 32'b001);
      La = C_RED;
      tick(1);
      check("code_sticky", 32'(err), 32'b001);
      do_reset();

      // Conflict: A green with B yellow (B RED->YELLOW also flags a transition).
      La = C_GREEN;
      Lb = C_YELLOW;
      tick(1);
      check("conflict_bit", 32'(err[2]), 32'd1);
      check("conflict_err", 32'(err), 32'b110);
      do_reset();
      check("post_reset_err", 32'(err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl_sensor.md
TL_SENSOR -- requirements
Module: tl_sensor

Interface
REQ-001 SHALL have parameter QW, default 4, meaning queue counter width (max count 2^QW-1).
REQ-002 SHALL have parameter DEPART_CYCLES, default 3, meaning green cycles per vehicle departure (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port arr_a  input  1  one-cycle vehicle-arrival pulse, street A.
REQ-006 SHALL have port arr_b  input  1  one-cycle vehicle-arrival pulse, street B.
REQ-007 SHALL have port La  input  2  street-A light code from the controller (GREEN=00, YELLOW=01, RED=11; 10 illegal).
REQ-008 SHALL have port Lb  input  2  street-B light code, same encoding.
REQ-009 SHALL have port Ta  output  1  street-A traffic present (to controller).
REQ-010 SHALL have port Tb  output  1  street-B traffic present (to controller).
REQ-011 SHALL have port qa  output  QW  street-A queue count.
REQ-012 SHALL have port qb  output  QW  street-B queue count.
REQ-013 SHALL have port ovf  output  2  sticky overflow flags, bit0 street A, bit1 street B.
REQ-014 SHALL have port err  output  3  sticky light-monitor errors: bit0 illegal code, bit1 illegal transition, bit2 conflict.

Function
REQ-015 Queue SHALL increment on each cycle its arrival pulse is high, update visible one edge later.
REQ-016 Ta SHALL equal (qa != 0) and Tb SHALL equal (qb != 0), decoded from the registered counts with no extra latency.
REQ-017 Each street SHALL have a departure timer: counts while its light is GREEN and its queue is nonzero; when it reaches DEPART_CYCLES-1 a departure occurs (queue decrements) and the timer returns to 0.
REQ-018 Timer SHALL clear to 0 on any cycle the light is not GREEN or the queue is 0; first departure therefore occurs on the DEPART_CYCLES-th consecutive green, nonempty cycle.
REQ-019 YELLOW and RED SHALL allow no departures.
REQ-020 Arrival and departure in the same cycle SHALL leave the queue unchanged.
REQ-021 Arrival at full count (2^QW-1) without simultaneous departure SHALL be dropped and set the street's ovf bit.
REQ-022 Queue SHALL never decrement below 0.
REQ-023 Monitor SHALL register previous La/Lb each cycle and evaluate the current values against them.
REQ-024 err[0] SHALL set when La or Lb equals 10.
REQ-025 err[1] SHALL set when a light changes GREEN->RED, RED->YELLOW, or YELLOW->GREEN; unchanged values never flag.
REQ-026 err[2] SHALL set when neither La nor Lb is RED.
REQ-027 All ovf/err bits SHALL become visible one edge after the offending input cycle and hold until reset.
REQ-028 Departure logic SHALL treat code 10 as not GREEN.

Reset
REQ-029 While reset_n is low: qa=qb=0, Ta=Tb=0, timers=0, ovf=00, err=000, previous La=GREEN, previous Lb=RED (matches controller reset state).
REQ-030 Reset asserted mid-operation SHALL clear all state immediately, regardless of clk; arrivals in that cycle are lost.

Structure
REQ-031 Color codes (GREEN, YELLOW, RED) and controller state encodings SHALL live in shared package tl_pkg, used by both controller and this block.
REQ-032 Per-street queue plus departure timer SHALL be sub-module tl_queue, instantiated twice; monitor stays in tl_sensor.

Verification (QW=4, DEPART_CYCLES=3)
REQ-033 Reset -> qa=qb=0, Ta=Tb=0, ovf=00, err=000.
REQ-034 La=RED,Lb=GREEN, three arr_a pulses -> qa=3, Ta=1; then La=YELLOW 1 cycle, La=GREEN held, Lb=RED -> qa reaches 2,1,0 after 3rd,6th,9th green edge; Ta=0 after 9th.
REQ-035 qa=15, La=RED, arr_a pulse -> qa stays 15, ovf=01; qb unaffected.
REQ-036 La=GREEN, qa=2, arr_a pulse on departure cycle -> qa stays 2, ovf=00.
REQ-037 La GREEN->RED directly with Lb=RED -> err=010 next edge, held after legal sequence resumes.
REQ-038 La=10 -> err[0]=1; separately La=GREEN,Lb=YELLOW -> err[2]=1; reset clears both.
